// File: rtl/sync_down_timer.sv
// sync_down_timer: loadable synchronous down counter/timer with terminal-count pulse,
// one-shot or auto-reload operation.
module sync_down_timer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             start,
    input  logic             stop,
    input  logic             auto_reload,
    output logic [WIDTH-1:0] Q,
    output logic             busy,
    output logic             tc,
    output logic             done
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] reload_reg;

    assign busy = state == RUN;
    assign done = state == DONE;

    always_ff @(posedge clk) begin
        if (reset) begin
            Q          <= '0;
            reload_reg <= '0;
            state      <= IDLE;
            tc         <= 1'b0;
        end else if (load) begin
            reload_reg <= load_val;
            Q          <= load_val;
            state      <= IDLE;
            tc         <= 1'b0;
        end else begin
            tc <= 1'b0;
            if (state == RUN) begin
                if (stop) state <= IDLE;
                else if (Q > WIDTH'(1)) Q <= Q - WIDTH'(1);
                else if (Q == WIDTH'(1)) begin
                    Q  <= '0;
                    tc <= 1'b1;
                end
                else if (auto_reload) Q <= reload_reg;
                else state <= DONE;
            end else if (start && !stop) begin
                // A held nonzero count resumes; an expired count restarts from reload_reg
                if (state == IDLE && Q != '0) state <= RUN;
                else if (reload_reg != '0) begin
                    Q     <= reload_reg;
                    state <= RUN;
                end else begin
                    state <= DONE;
                    tc    <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_sync_down_timer.sv
// tb_sync_down_timer: directed self-checking bench for sync_down_timer (WIDTH=4).
module tb_sync_down_timer;
    logic       clk = 1'b0;
    logic       reset, load, start, stop, auto_reload;
    logic [3:0] load_val;
    logic [3:0] Q;
    logic       busy, tc, done;
    int         checks = 0;
    int         errors = 0;

    sync_down_timer #(.WIDTH(4)) dut (
        .clk(clk), .reset(reset), .load(load), .load_val(load_val),
        .start(start), .stop(stop), .auto_reload(auto_reload),
        .Q(Q), .busy(busy), .tc(tc), .done(done)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int q, input int b, input int t, input int d);
        chk({tag, ".Q"}, int'(Q), q);
        chk({tag, ".busy"}, int'(busy), b);
        chk({tag, ".tc"}, int'(tc), t);
        chk({tag, ".done"}, int'(done), d);
    endtask

    task automatic do_load(input int v);
        load = 1'b1;
        load_val = 4'(v);
        step();
        load = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    initial begin
        reset = 1'b1; load = 1'b0; start = 1'b0; stop = 1'b0; auto_reload = 1'b0; load_val = '0;
        step();
        step();
        reset = 1'b0;
        chk_all("reset", 0, 0, 0, 0);

        // one-shot from 5
        do_load(5);
        chk_all("t1_load", 5, 0, 0, 0);
        do_start();
        chk_all("t1_start", 5, 1, 0, 0);
        for (int v = 4; v >= 0; v--) begin
            step();
            chk_all("t1_cnt", v, 1, v == 0 ? 1 : 0, 0);
        end
        step();
        chk_all("t1_done", 0, 0, 0, 1);
        step();
        chk_all("t1_hold", 0, 0, 0, 1);

        // auto-reload from 3
        auto_reload = 1'b1;
        do_load(3);
        do_start();
        chk_all("t2_start", 3, 1, 0, 0);
        for (int i = 0; i < 8; i++) begin
            step();
            chk_all("t2_cnt", (2 - i) & 3, 1, (i % 4) == 2 ? 1 : 0, 0);
        end

        // stop and resume from 9
        auto_reload = 1'b0;
        do_load(9);
        chk_all("t3_load", 9, 0, 0, 0);
        do_start();
        for (int v = 8; v >= 5; v--) begin
            step();
            chk_all("t3_cnt", v, 1, 0, 0);
        end
        stop = 1'b1;
        step();
        stop = 1'b0;
        chk_all("t3_stop", 5, 0, 0, 0);
        step();
        chk_all("t3_idle", 5, 0, 0, 0);
        do_start();
        chk_all("t3_resume", 5, 1, 0, 0);
        for (int v = 4; v >= 0; v--) begin
            step();
            chk_all("t3_cnt2", v, 1, v == 0 ? 1 : 0, 0);
        end

        // zero reload: immediate expiry
        do_load(0);
        do_start();
        chk_all("t4_zero", 0, 0, 1, 1);
        step();
        chk_all("t4_zero2", 0, 0, 0, 1);
        load = 1'b1; start = 1'b1; load_val = 4'd2;
        step();
        load = 1'b0; start = 1'b0;
        chk_all("t4_ldwin", 2, 0, 0, 0);
        step();
        chk_all("t4_ldhold", 2, 0, 0, 0);

        // reset mid-count
        do_load(12);
        do_start();
        for (int v = 11; v >= 7; v--) step();
        chk_all("t5_pre", 7, 1, 0, 0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk_all("t5_reset", 0, 0, 0, 0);
        do_start();
        chk_all("t5_rl0", 0, 0, 1, 1);
        do_load(4);
        start = 1'b1; stop = 1'b1;
        step();
        start = 1'b0; stop = 1'b0;
        chk_all("t5_ststp", 4, 0, 0, 0);

        // full-range one-shot, then restart from DONE
        do_load(15);
        do_start();
        chk_all("t6_start", 15, 1, 0, 0);
        for (int v = 14; v >= 0; v--) begin
            step();
            chk_all("t6_cnt", v, 1, v == 0 ? 1 : 0, 0);
        end
        step();
        chk_all("t6_done", 0, 0, 0, 1);
        do_start();
        chk_all("t6_restart", 15, 1, 0, 0);
        step();
        chk_all("t6_cont", 14, 1, 0, 0);

        // reload of 1 with auto-reload: tc every other cycle
        auto_reload = 1'b1;
        do_load(1);
        do_start();
        chk_all("t7_start", 1, 1, 0, 0);
        for (int i = 0; i < 4; i++) begin
            step();
            chk_all("t7_cnt", (i % 2) == 0 ? 0 : 1, 1, (i % 2) == 0 ? 1 : 0, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
